// File: rtl/laser_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : laser_pkg
//  Description : Shared types and defaults for the laser receive FIFO slice.
//                Holds the default byte width, the default FIFO depth, the
//                16-bit word type {laser1 byte, laser2 byte} and a helper
//                that sizes the occupancy counter for a given depth.
//  Revision    : 1.0  initial release
// ============================================================================
package laser_pkg;

    localparam int LASER_BYTE_W     = 8;
    localparam int LASER_FIFO_DEPTH = 16;

    typedef logic [2*LASER_BYTE_W-1:0] laser_word_t;

    // Occupancy counter must represent 0..DEPTH inclusive, hence one extra bit.
    function automatic int laser_count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/laser_rx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : laser_rx_fifo_if
//  Description : Bundle of the laser receive FIFO data/handshake signals.
//                master : producer/consumer side (drives strobe, bytes,
//                         rd_en, clear_overflow; observes status and data)
//                slave  : FIFO side
//  Signals     : data_valid, data1_in, data2_in, rd_en, clear_overflow,
//                rd_data, rd_valid, empty, full, count, overflow, last_word
//  Revision    : 1.0  initial release
// ============================================================================
interface laser_rx_fifo_if
    import laser_pkg::*;
#(
    parameter int DEPTH  = LASER_FIFO_DEPTH,
    parameter int BYTE_W = LASER_BYTE_W
) ();

    logic                              data_valid;
    logic [BYTE_W-1:0]                 data1_in;
    logic [BYTE_W-1:0]                 data2_in;
    logic                              rd_en;
    logic                              clear_overflow;
    logic [2*BYTE_W-1:0]               rd_data;
    logic                              rd_valid;
    logic                              empty;
    logic                              full;
    logic [laser_count_w(DEPTH)-1:0]   count;
    logic                              overflow;
    logic [2*BYTE_W-1:0]               last_word;

    modport master (
        output data_valid, data1_in, data2_in, rd_en, clear_overflow,
        input  rd_data, rd_valid, empty, full, count, overflow, last_word
    );

    modport slave (
        input  data_valid, data1_in, data2_in, rd_en, clear_overflow,
        output rd_data, rd_valid, empty, full, count, overflow, last_word
    );

endinterface
`default_nettype wire

// File: rtl/laser_rx_fifo_rise_detect.sv
`default_nettype none
// ============================================================================
//  Module      : rise_detect
//  Description : One-cycle pulse on a 0->1 transition of a level input.
//                The history register resets to 1 so a level that is already
//                high when reset is released is not seen as a new edge.
//  Ports       : clock, reset (async, active-high), level -> pulse
//  Revision    : 1.0  initial release
// ============================================================================
module rise_detect (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic level,
    output logic      pulse
);

    logic r_level_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_level_d <= 1'b1;
        end else begin
            r_level_d <= level;
        end
    end

    assign pulse = level & ~r_level_d;

endmodule
`default_nettype wire

// File: rtl/laser_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : laser_rx_fifo
//  Description : Receive FIFO for paired laser bytes. Each rising edge of
//                data_valid captures {data1_in, data2_in}; words are read
//                in order with one cycle of latency. Overflow is sticky.
//  Ports       : clock, reset (async, active-high)
//                bus (laser_rx_fifo_if.slave) - strobe, bytes, read request,
//                overflow clear, read data/valid, status and last word
//  Revision    : 1.0  initial release
// ============================================================================
module laser_rx_fifo
    import laser_pkg::*;
#(
    parameter int DEPTH  = LASER_FIFO_DEPTH,
    parameter int BYTE_W = LASER_BYTE_W
) (
    input  wire logic       clock,
    input  wire logic       reset,
    laser_rx_fifo_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = laser_count_w(DEPTH);
    localparam logic [CW-1:0] c_full_count = CW'(DEPTH);

    logic                  w_capture;
    logic [2*BYTE_W-1:0]   w_word;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_drop;
    logic [CW-1:0]         w_count_nxt;

    logic [2*BYTE_W-1:0]   r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_overflow;
    logic                  r_rd_valid;
    logic [2*BYTE_W-1:0]   r_rd_data;
    logic [2*BYTE_W-1:0]   r_last_word;

    rise_detect u_rise_detect (
        .clock (clock),
        .reset (reset),
        .level (bus.data_valid),
        .pulse (w_capture)
    );

    assign w_word = {bus.data1_in, bus.data2_in};

    // A read frees a slot in the same cycle, so a write at full is still
    // accepted when accompanied by an accepted read. When full, the write
    // slot equals the read slot; the read samples the old contents first.
    always_comb begin
        w_rd_acc    = bus.rd_en & ~r_empty;
        w_wr_acc    = w_capture & (~r_full | w_rd_acc);
        w_drop      = w_capture & ~w_wr_acc;
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array carries no reset so it maps onto plain registers/RAM.
    always_ff @(posedge clock) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_overflow  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_last_word <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rd_data <= r_mem[r_rd_ptr];
            end
            r_rd_valid <= w_rd_acc;
            r_count    <= w_count_nxt;
            r_empty    <= (w_count_nxt == '0);
            r_full     <= (w_count_nxt == c_full_count);
            // Display word tracks every capture, even ones that get dropped.
            if (w_capture) begin
                r_last_word <= w_word;
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.rd_data   = r_rd_data;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.empty     = r_empty;
    assign bus.full      = r_full;
    assign bus.count     = r_count;
    assign bus.overflow  = r_overflow;
    assign bus.last_word = r_last_word;

endmodule
`default_nettype wire

// File: tb/tb_laser_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_laser_rx_fifo
//  Description : Directed self-checking bench for laser_rx_fifo (DEPTH=16).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_laser_rx_fifo;
    import laser_pkg::*;

    localparam int DEPTH  = 16;
    localparam int BYTE_W = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    laser_rx_fifo_if #(.DEPTH(DEPTH), .BYTE_W(BYTE_W)) bus ();

    laser_rx_fifo #(.DEPTH(DEPTH), .BYTE_W(BYTE_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic capture(input logic [7:0] b1, input logic [7:0] b2);
        bus.data1_in   = b1;
        bus.data2_in   = b2;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        total++;
        if ({bus.count, bus.empty, bus.full, bus.overflow, bus.rd_valid} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_status got=%b exp=%b",
                     {bus.count, bus.empty, bus.full, bus.overflow, bus.rd_valid}, {5'd0, 4'b1000});
        end
        total++;
        if ({bus.rd_data, bus.last_word} !== 32'h0) begin
            bad++;
            $display("FAIL reset_data got=%h exp=%h", {bus.rd_data, bus.last_word}, 32'h0);
        end
    endtask

    task automatic test_hold_capture();
        bus.data1_in   = 8'h12;
        bus.data2_in   = 8'h34;
        bus.data_valid = 1'b1;
        repeat (5) tick();
        bus.data_valid = 1'b0;
        tick();
        total++;
        if (bus.count !== 5'd1) begin
            bad++; $display("FAIL hold_count got=%0d exp=1", bus.count);
        end
        total++;
        if (bus.last_word !== 16'h1234) begin
            bad++; $display("FAIL hold_last_word got=%h exp=1234", bus.last_word);
        end
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        total++;
        if ({bus.rd_valid, bus.rd_data, bus.empty} !== {1'b1, 16'h1234, 1'b1}) begin
            bad++; $display("FAIL hold_read got=%h exp=%h", {bus.rd_valid, bus.rd_data, bus.empty}, {1'b1, 16'h1234, 1'b1});
        end
        tick();
        total++;
        if (bus.rd_valid !== 1'b0) begin
            bad++; $display("FAIL hold_rd_valid_pulse got=%b exp=0", bus.rd_valid);
        end
    endtask

    task automatic test_empty_simul();
        bus.data1_in   = 8'h55;
        bus.data2_in   = 8'h66;
        bus.data_valid = 1'b1;
        bus.rd_en      = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        bus.rd_en      = 1'b0;
        total++;
        if ({bus.rd_valid, bus.count, bus.empty} !== {1'b0, 5'd1, 1'b0}) begin
            bad++; $display("FAIL empty_simul_status got=%b exp=%b", {bus.rd_valid, bus.count, bus.empty}, {1'b0, 5'd1, 1'b0});
        end
        total++;
        if (bus.rd_data !== 16'h1234) begin
            bad++; $display("FAIL empty_simul_rd_hold got=%h exp=1234", bus.rd_data);
        end
        tick();
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        total++;
        if ({bus.rd_valid, bus.rd_data, bus.empty} !== {1'b1, 16'h5566, 1'b1}) begin
            bad++; $display("FAIL empty_simul_read got=%h exp=%h", {bus.rd_valid, bus.rd_data, bus.empty}, {1'b1, 16'h5566, 1'b1});
        end
        tick();
    endtask

    task automatic test_overflow();
        laser_word_t exp;
        for (int i = 0; i < 16; i++) begin
            capture(8'(i), 8'(i));
        end
        total++;
        if ({bus.full, bus.count, bus.overflow} !== {1'b1, 5'd16, 1'b0}) begin
            bad++; $display("FAIL ovf_full got=%b exp=%b", {bus.full, bus.count, bus.overflow}, {1'b1, 5'd16, 1'b0});
        end
        // 17th capture dropped while a clear is requested: set must win.
        bus.data1_in       = 8'd16;
        bus.data2_in       = 8'd16;
        bus.data_valid     = 1'b1;
        bus.clear_overflow = 1'b1;
        tick();
        bus.data_valid     = 1'b0;
        bus.clear_overflow = 1'b0;
        total++;
        if (bus.overflow !== 1'b1) begin
            bad++; $display("FAIL ovf_set got=%b exp=1", bus.overflow);
        end
        total++;
        if ({bus.last_word, bus.count} !== {16'h1010, 5'd16}) begin
            bad++; $display("FAIL ovf_last_word got=%h exp=%h", {bus.last_word, bus.count}, {16'h1010, 5'd16});
        end
        tick();
        bus.rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            exp = {8'(i), 8'(i)};
            total++;
            if ({bus.rd_valid, bus.rd_data} !== {1'b1, exp}) begin
                bad++; $display("FAIL ovf_read_%0d got=%h exp=%h", i, {bus.rd_valid, bus.rd_data}, {1'b1, exp});
            end
        end
        bus.rd_en = 1'b0;
        total++;
        if ({bus.empty, bus.overflow} !== 2'b11) begin
            bad++; $display("FAIL ovf_drained got=%b exp=11", {bus.empty, bus.overflow});
        end
        bus.clear_overflow = 1'b1;
        tick();
        bus.clear_overflow = 1'b0;
        total++;
        if (bus.overflow !== 1'b0) begin
            bad++; $display("FAIL ovf_clear got=%b exp=0", bus.overflow);
        end
    endtask

    task automatic test_full_simul();
        laser_word_t exp;
        for (int i = 0; i < 16; i++) begin
            capture(8'hA0 + 8'(i), 8'h0F);
        end
        bus.data1_in   = 8'hBB;
        bus.data2_in   = 8'hCC;
        bus.data_valid = 1'b1;
        bus.rd_en      = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        bus.rd_en      = 1'b0;
        total++;
        if ({bus.count, bus.full, bus.overflow} !== {5'd16, 1'b1, 1'b0}) begin
            bad++; $display("FAIL full_simul_status got=%b exp=%b", {bus.count, bus.full, bus.overflow}, {5'd16, 1'b1, 1'b0});
        end
        total++;
        if ({bus.rd_valid, bus.rd_data} !== {1'b1, 16'hA00F}) begin
            bad++; $display("FAIL full_simul_oldest got=%h exp=%h", {bus.rd_valid, bus.rd_data}, {1'b1, 16'hA00F});
        end
        bus.rd_en = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            tick();
            exp = (j < 16) ? {8'hA0 + 8'(j), 8'h0F} : 16'hBBCC;
            total++;
            if (bus.rd_data !== exp) begin
                bad++; $display("FAIL full_simul_read_%0d got=%h exp=%h", j, bus.rd_data, exp);
            end
        end
        bus.rd_en = 1'b0;
        total++;
        if ({bus.empty, bus.count} !== {1'b1, 5'd0}) begin
            bad++; $display("FAIL full_simul_drained got=%b exp=%b", {bus.empty, bus.count}, {1'b1, 5'd0});
        end
        tick();
    endtask

    task automatic test_wrap();
        laser_word_t exp;
        for (int i = 0; i < 5; i++) begin
            capture(8'(i), 8'(i) ^ 8'h5A);
        end
        for (int i = 5; i < 40; i++) begin
            bus.data1_in   = 8'(i);
            bus.data2_in   = 8'(i) ^ 8'h5A;
            bus.data_valid = 1'b1;
            bus.rd_en      = 1'b1;
            tick();
            bus.data_valid = 1'b0;
            bus.rd_en      = 1'b0;
            exp = {8'(i - 5), 8'(i - 5) ^ 8'h5A};
            total++;
            if ({bus.rd_valid, bus.rd_data, bus.count} !== {1'b1, exp, 5'd5}) begin
                bad++; $display("FAIL wrap_read_%0d got=%h exp=%h", i - 5, {bus.rd_valid, bus.rd_data, bus.count}, {1'b1, exp, 5'd5});
            end
            tick();
        end
        bus.rd_en = 1'b1;
        for (int i = 35; i < 40; i++) begin
            tick();
            exp = {8'(i), 8'(i) ^ 8'h5A};
            total++;
            if (bus.rd_data !== exp) begin
                bad++; $display("FAIL wrap_drain_%0d got=%h exp=%h", i, bus.rd_data, exp);
            end
        end
        bus.rd_en = 1'b0;
        total++;
        if ({bus.count, bus.empty} !== {5'd0, 1'b1}) begin
            bad++; $display("FAIL wrap_final got=%b exp=%b", {bus.count, bus.empty}, {5'd0, 1'b1});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) begin
            capture(8'h70 + 8'(i), 8'h01);
        end
        total++;
        if (bus.count !== 5'd7) begin
            bad++; $display("FAIL rst_mid_prefill got=%0d exp=7", bus.count);
        end
        bus.data1_in   = 8'h99;
        bus.data2_in   = 8'h99;
        bus.data_valid = 1'b1;
        reset          = 1'b1;
        #1;
        total++;
        if ({bus.count, bus.empty} !== {5'd0, 1'b1}) begin
            bad++; $display("FAIL rst_mid_async got=%b exp=%b", {bus.count, bus.empty}, {5'd0, 1'b1});
        end
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();
        total++;
        if ({bus.count, bus.empty, bus.last_word} !== {5'd0, 1'b1, 16'h0000}) begin
            bad++; $display("FAIL rst_mid_no_capture got=%h exp=%h", {bus.count, bus.empty, bus.last_word}, {5'd0, 1'b1, 16'h0000});
        end
        bus.data_valid = 1'b0;
        tick();
        bus.data1_in   = 8'h77;
        bus.data2_in   = 8'h88;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        total++;
        if ({bus.count, bus.last_word} !== {5'd1, 16'h7788}) begin
            bad++; $display("FAIL rst_mid_recapture got=%h exp=%h", {bus.count, bus.last_word}, {5'd1, 16'h7788});
        end
        tick();
    endtask

    initial begin
        bus.data_valid     = 1'b0;
        bus.data1_in       = '0;
        bus.data2_in       = '0;
        bus.rd_en          = 1'b0;
        bus.clear_overflow = 1'b0;
        reset              = 1'b1;
        tick();
        tick();
        test_reset();
        reset = 1'b0;
        tick();
        test_hold_capture();
        test_empty_simul();
        test_overflow();
        test_full_simul();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/laser_rx_fifo.md
LASER_RX_FIFO -- requirements
Module: laser_rx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning number of 16-bit word entries (power of two, 4..256).
REQ-002 The block SHALL have parameter BYTE_W, default 8, meaning width of each laser channel byte.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clock  input  1  system clock (CLOCK_50 domain).
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 data_valid  input  1  receiver strobe; high for one or more cycles per received byte pair.
REQ-007 data1_in  input  BYTE_W  laser 1 received byte.
REQ-008 data2_in  input  BYTE_W  laser 2 received byte.
REQ-009 rd_en  input  1  consumer read request.
REQ-010 clear_overflow  input  1  clears the sticky overflow flag.
REQ-011 rd_data  output  2*BYTE_W  {laser1 byte, laser2 byte} of the word read.
REQ-012 rd_valid  output  1  rd_data holds a newly read word this cycle.
REQ-013 empty  output  1  no words stored.
REQ-014 full  output  1  DEPTH words stored.
REQ-015 count  output  $clog2(DEPTH)+1  number of words stored.
REQ-016 overflow  output  1  sticky flag: at least one word was dropped.
REQ-017 last_word  output  2*BYTE_W  most recently captured word, for the seven-segment display.

Function
REQ-018 Capture SHALL occur on the rising edge of data_valid only: a write is requested in the cycle in which data_valid=1 and data_valid was 0 in the previous cycle; holding data_valid high SHALL NOT produce further writes.
REQ-019 The captured word SHALL be {data1_in, data2_in} sampled in the same cycle the rising edge is detected.
REQ-020 last_word SHALL update on every detected capture, including captures dropped on overflow.
REQ-021 A write while not full SHALL store the word at the write pointer and advance it modulo DEPTH.
REQ-022 A write while full with no accepted read in the same cycle SHALL be dropped and SHALL set overflow to 1 in the next cycle.
REQ-023 rd_en while empty SHALL be ignored; rd_valid stays 0 and rd_data holds its value.
REQ-024 rd_en while not empty SHALL be accepted: rd_data is loaded with the oldest word and rd_valid=1 in the next cycle (latency 1); the read pointer advances modulo DEPTH.
REQ-025 rd_valid SHALL be high for exactly one cycle per accepted read.
REQ-026 Simultaneous write and accepted read while full SHALL perform both; count stays DEPTH, overflow is unchanged.
REQ-027 Simultaneous write and rd_en while empty SHALL perform only the write; count becomes 1.
REQ-028 Simultaneous write and accepted read otherwise SHALL leave count unchanged.
REQ-029 count, empty and full SHALL be registered and consistent in the same cycle: empty = (count==0), full = (count==DEPTH).
REQ-030 Pointer wrap-around SHALL be transparent: words SHALL be read in write order across any number of wraps.
REQ-031 clear_overflow=1 SHALL clear overflow in the next cycle; if a dropped write and clear_overflow coincide, overflow SHALL be 1 (set wins).

Reset
REQ-032 While reset=1: pointers=0, count=0, empty=1, full=0, overflow=0, rd_valid=0, rd_data=0, last_word=0, and the previous-data_valid register=1, so that a data_valid already high when reset is released is not captured.
REQ-033 Reset asserted mid-operation SHALL discard all stored words immediately; storage array contents need not be cleared.

Structure
REQ-034 A shared package laser_pkg SHALL hold BYTE_W default, a laser_word_t typedef of 2*BYTE_W bits, and the default FIFO depth constant.
REQ-035 The rising-edge detector SHALL be a sub-module named rise_detect (inputs clock, reset, level; output pulse).
REQ-036 Storage SHALL be an inferable register array with no reset on its contents.

Verification
REQ-037 Hold data_valid high 5 cycles with data1_in=8'h12, data2_in=8'h34, then read once -> exactly one write, count=1, and one cycle after rd_en: rd_data=16'h1234, rd_valid=1, empty=1.
REQ-038 Issue 17 capture pulses with bytes 0..16 at DEPTH=16 and no reads -> full=1 after the 16th, overflow=1 after the 17th, last_word={8'd16,8'd16}, and 16 reads return 0..15 in order.
REQ-039 At full, pulse data_valid and rd_en in the same cycle -> count stays 16, overflow stays 0, oldest word returned, new word read last.
REQ-040 At empty, pulse data_valid and rd_en in the same cycle -> rd_valid=0 next cycle, count=1.
REQ-041 Perform 40 write/read pairs through DEPTH=16 -> all 40 words returned in order (pointer wrap), and count returns to 0.
REQ-042 Assert reset with count=7 and data_valid high, then release -> count=0, empty=1, no capture until data_valid falls and rises again.
